matrix_mult_controller: RTL and testbench
=========================================

# matrix_mult_controller

Sequencing controller that computes a DIM×DIM product of unsigned 4-bit matrices, C = A·B, by time-sharing one instance of the team's combinational 4×4 array multiplier (`matrix_multiplication_module`, 4-bit A/B in, 8-bit P out). It accepts one operand pair through a valid/ready handshake and issues one element product per cycle. It accumulates the dot products and presents the full result matrix through a valid/ready output handshake. It sits between the operand source and the consumer of matrix results.

## Interface
- DIM, default 2: matrix dimension; legal 2..4.
- Derived, not overridable:
  - ACC_W = 8 + $clog2(DIM), the result element width.
  - Element (r,c) of any matrix sits at flat index r*DIM+c.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  operand pair on a_in/b_in is valid.
- in_ready  output  1  controller can accept an operand pair.
- a_in  input  4*DIM*DIM  matrix A; element k occupies bits [4k+3:4k].
- b_in  input  4*DIM*DIM  matrix B, same packing as A.
- out_valid  output  1  c_out holds a complete result.
- out_ready  input  1  consumer accepts c_out.
- c_out  output  ACC_W*DIM*DIM  matrix C; element k occupies bits [ACC_W*k+ACC_W-1:ACC_W*k].
- busy  output  1  high in every state except IDLE.

## Operation
- States:
  - IDLE: in_ready=1.
  - MAC: multiply-accumulate.
  - DONE: out_valid=1.
- IDLE → MAC on in_valid & in_ready. a_in and b_in are latched into internal operand registers in that cycle. Later changes on a_in/b_in have no effect.
- MAC uses counters i (row), j (column), k (inner), each 0..DIM-1. Iteration order is i outer, j middle, k inner.
- Each MAC cycle:
  - Drive the multiplier with A[i][k] and B[k][j].
  - If k=0, acc ← P. Otherwise acc ← acc + P.
  - If k=DIM-1, write (k=0 ? P : acc+P) into C[i][j].
- Exactly one multiplier instance exists. Exactly one product is consumed per cycle. There is no idle cycle between products.
- MAC → DONE after the cycle with i=j=k=DIM-1.
- DONE → IDLE on out_valid & out_ready.
- in_valid is ignored outside IDLE; no operand is queued.
- Arithmetic is unsigned. ACC_W bits always hold DIM·225 without overflow. Products are zero-extended to ACC_W. No saturation or wrap logic is needed.
- c_out:
  - Driven directly from the result registers.
  - Contents may change during MAC; meaningful only while out_valid=1.
  - Bit-stable for the whole time out_valid=1.
  - Retains its last value in IDLE until overwritten by the next MAC.
- Reset:
  - Applies at any time, including mid-MAC or in DONE.
  - The state machine goes to IDLE.
  - Counters, acc, operand registers and c_out are cleared to 0.
  - The in-flight computation is discarded without a partial out_valid.
- Reset values: in_ready=1, out_valid=0, busy=0, c_out=0.

## Timing
- Input handshake in cycle T.
- MAC occupies cycles T+1 … T+DIM³ (8 cycles for DIM=2).
- out_valid rises at T+DIM³+1 and stays high until the cycle in which out_ready=1; that cycle completes the transfer.
- in_ready rises the cycle after the output transfer.
- Minimum spacing between accepted operand pairs is DIM³+2 cycles. This requires out_ready held high.
- in_ready, out_valid and busy are registered state decodes. They have no combinational path from in_valid or out_ready.
- The multiplier path is combinational within one cycle: operand register → multiplier → adder → acc/C register.

## Test plan
- Basic product, DIM=2:
  - Stimulus: a_in=16'h4321 ([[1,2],[3,4]]), b_in=16'h8765 ([[5,6],[7,8]]), out_ready=1.
  - Response: c_out elements {19,22,43,50}; out_valid exactly 9 cycles after the input handshake.
- Max values:
  - Stimulus: all elements 15, DIM=2.
  - Response: every c_out element = 450, no overflow.
  - Repeat with DIM=4: every element = 900.
- Identity: A=I, B=16'hFA50. Response: c_out = B elements {0,5,10,15}.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles after out_valid rises.
  - Response: out_valid stays 1, c_out stable, in_ready stays 0; a pulse on in_valid meanwhile is ignored.
  - Then out_ready=1: out_valid falls the next cycle, and in_ready rises.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 asynchronously at MAC cycle 4.
  - Response: outputs immediately read in_ready=1, out_valid=0, busy=0, c_out=0.
  - A fresh operand pair then yields the correct result.
- Back-to-back: two operand pairs with in_valid held high and out_ready=1. Response: the second is accepted exactly DIM³+2 cycles after the first, and both results are correct.

Source files
------------

// File: rtl/matrix_mult_controller.sv
// DIMxDIM unsigned 4-bit matrix product on one shared multiplier, one element product per cycle.
// Latency DIM^3+1 cycles from input handshake to out_valid; result held until out_ready.

module matrix_multiplication_module (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic [7:0] o_p
);
  logic [7:0] w_pp [4];

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      w_pp[n] = i_b[n] ? ({4'b0000, i_a} << n) : 8'd0;
    end
  end

  assign o_p = w_pp[0] + w_pp[1] + w_pp[2] + w_pp[3];
endmodule

module matrix_mult_controller #(
  parameter  int DIM   = 2,
  localparam int ACC_W = 8 + $clog2(DIM)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [4*DIM*DIM-1:0]       a_in,
  input  logic [4*DIM*DIM-1:0]       b_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACC_W*DIM*DIM-1:0]   c_out,
  output logic                       busy
);
  localparam int CW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIM - 1);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

  state_t                 r_state;
  logic [4*DIM*DIM-1:0]   r_a;
  logic [4*DIM*DIM-1:0]   r_b;
  logic [CW-1:0]          r_i;
  logic [CW-1:0]          r_j;
  logic [CW-1:0]          r_k;
  logic [ACC_W-1:0]       r_acc;
  logic [ACC_W-1:0]       r_c [DIM][DIM];
  logic                   r_in_ready;
  logic                   r_out_valid;
  logic                   r_busy;

  logic [3:0]             w_a_mat [DIM][DIM];
  logic [3:0]             w_b_mat [DIM][DIM];
  logic [3:0]             w_mul_a;
  logic [3:0]             w_mul_b;
  logic [7:0]             w_p;
  logic [ACC_W-1:0]       w_p_ext;
  logic [ACC_W-1:0]       w_sum;

  for (genvar r = 0; r < DIM; r++) begin : g_row
    for (genvar c = 0; c < DIM; c++) begin : g_col
      assign w_a_mat[r][c] = r_a[4*(r*DIM+c) +: 4];
      assign w_b_mat[r][c] = r_b[4*(r*DIM+c) +: 4];
      assign c_out[ACC_W*(r*DIM+c) +: ACC_W] = r_c[r][c];
    end
  end

  assign w_mul_a = w_a_mat[r_i][r_k];
  assign w_mul_b = w_b_mat[r_k][r_j];

  matrix_multiplication_module u_mul (
    .i_a (w_mul_a),
    .i_b (w_mul_b),
    .o_p (w_p)
  );

  // First term of each dot product restarts the accumulator instead of adding.
  assign w_p_ext = {{(ACC_W-8){1'b0}}, w_p};
  assign w_sum   = (r_k == '0) ? w_p_ext : r_acc + w_p_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_i         <= '0;
      r_j         <= '0;
      r_k         <= '0;
      r_acc       <= '0;
      for (int r = 0; r < DIM; r++) begin
        for (int c = 0; c < DIM; c++) begin
          r_c[r][c] <= '0;
        end
      end
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a        <= a_in;
            r_b        <= b_in;
            r_i        <= '0;
            r_j        <= '0;
            r_k        <= '0;
            r_state    <= S_MAC;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        S_MAC: begin
          r_acc <= w_sum;
          if (r_k == LAST) begin
            r_c[r_i][r_j] <= w_sum;
          end
          if (r_k != LAST) begin
            r_k <= r_k + CW'(1);
          end else begin
            r_k <= '0;
            if (r_j != LAST) begin
              r_j <= r_j + CW'(1);
            end else begin
              r_j <= '0;
              if (r_i != LAST) begin
                r_i <= r_i + CW'(1);
              end else begin
                r_i         <= '0;
                r_state     <= S_DONE;
                r_out_valid <= 1'b1;
              end
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
endmodule

// File: tb/tb_matrix_mult_controller.sv
// Directed bench for matrix_mult_controller: DIM=2 main instance plus a DIM=4 instance for max values.
module tb_matrix_mult_controller;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;

  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [15:0]  a_in = '0;
  logic [15:0]  b_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [35:0]  c_out;
  logic         busy;

  logic         in_valid4 = 1'b0;
  logic         in_ready4;
  logic [63:0]  a_in4 = '0;
  logic [63:0]  b_in4 = '0;
  logic         out_valid4;
  logic         out_ready4 = 1'b1;
  logic [159:0] c_out4;
  logic         busy4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  matrix_mult_controller #(.DIM(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
    .c_out(c_out), .busy(busy)
  );

  matrix_mult_controller #(.DIM(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a_in(a_in4), .b_in(b_in4), .out_valid(out_valid4), .out_ready(out_ready4),
    .c_out(c_out4), .busy(busy4)
  );

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Caller is at a negedge with the DUT idle; returns posedges counted from the handshake edge.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, output int lat);
    in_valid = 1'b1;
    a_in = a;
    b_in = b;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) break;
    end
  endtask

  initial begin
    int lat;
    int cnt;
    logic [35:0] e_basic;
    logic [35:0] e_max;
    logic [35:0] e_held;

    e_basic = {9'd50, 9'd43, 9'd22, 9'd19};
    e_max   = {9'd450, 9'd450, 9'd450, 9'd450};

    // Reset state
    #12;
    chk("rst_in_ready", 160'(in_ready), 160'(1));
    chk("rst_out_valid", 160'(out_valid), 160'(0));
    chk("rst_busy", 160'(busy), 160'(0));
    chk("rst_c_out", 160'(c_out), 160'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic product with exact latency
    out_ready = 1'b1;
    do_op(16'h4321, 16'h8765, lat);
    chk("basic_latency", 160'(lat), 160'(9));
    chk("basic_c_out", 160'(c_out), 160'(e_basic));
    @(negedge clk);
    chk("basic_ov_fall", 160'(out_valid), 160'(0));
    chk("basic_in_ready", 160'(in_ready), 160'(1));
    chk("basic_c_hold", 160'(c_out), 160'(e_basic));

    // Max values, DIM=2
    do_op(16'hFFFF, 16'hFFFF, lat);
    chk("max2_c_out", 160'(c_out), 160'(e_max));
    @(negedge clk);

    // Identity times B
    do_op(16'h1001, 16'hFA50, lat);
    chk("ident_c_out", 160'(c_out), 160'({9'd15, 9'd10, 9'd5, 9'd0}));
    @(negedge clk);

    // Max values, DIM=4
    in_valid4 = 1'b1;
    a_in4 = 64'hFFFF_FFFF_FFFF_FFFF;
    b_in4 = 64'hFFFF_FFFF_FFFF_FFFF;
    cnt = 0;
    while (cnt < 200) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      in_valid4 = 1'b0;
      if (out_valid4) break;
    end
    chk("max4_latency", 160'(cnt), 160'(65));
    chk("max4_c_out", c_out4, {16{10'd900}});
    @(negedge clk);

    // Backpressure with an ignored in_valid pulse
    out_ready = 1'b0;
    do_op(16'h4321, 16'h8765, lat);
    chk("bp_latency", 160'(lat), 160'(9));
    e_held = c_out;
    chk("bp_c_out", 160'(e_held), 160'(e_basic));
    for (int n = 0; n < 10; n++) begin
      in_valid = (n == 4);
      a_in = 16'hFFFF;
      b_in = 16'hFFFF;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      chk("bp_out_valid", 160'(out_valid), 160'(1));
      chk("bp_in_ready", 160'(in_ready), 160'(0));
      chk("bp_c_stable", 160'(c_out), 160'(e_basic));
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_ov_fall", 160'(out_valid), 160'(0));
    chk("bp_in_ready_rise", 160'(in_ready), 160'(1));
    chk("bp_busy", 160'(busy), 160'(0));
    chk("bp_c_after", 160'(c_out), 160'(e_basic));

    // Asynchronous reset in the fourth MAC cycle
    in_valid = 1'b1;
    a_in = 16'hFFFF;
    b_in = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mid_busy", 160'(busy), 160'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 160'(in_ready), 160'(1));
    chk("mid_rst_out_valid", 160'(out_valid), 160'(0));
    chk("mid_rst_busy", 160'(busy), 160'(0));
    chk("mid_rst_c_out", 160'(c_out), 160'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(16'h1234, 16'h5678, lat);
    chk("post_rst_latency", 160'(lat), 160'(9));
    chk("post_rst_c_out", 160'(c_out), 160'({9'd19, 9'd22, 9'd43, 9'd50}));
    @(negedge clk);

    // Back-to-back with in_valid held high
    in_valid = 1'b1;
    a_in = 16'h4321;
    b_in = 16'h8765;
    @(posedge clk);
    cnt = 0;
    @(negedge clk);
    a_in = 16'hFFFF;
    b_in = 16'hFFFF;
    while (cnt < 50) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      if (out_valid) chk("b2b_first_c_out", 160'(c_out), 160'(e_basic));
      if (in_ready) break;
    end
    chk("b2b_spacing", 160'(cnt + 1), 160'(10));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_second_busy", 160'(busy), 160'(1));
    cnt = 1;
    while (cnt < 100) begin
      if (out_valid) break;
      @(posedge clk);
      cnt++;
      @(negedge clk);
    end
    chk("b2b_second_latency", 160'(cnt), 160'(9));
    chk("b2b_second_c_out", 160'(c_out), 160'(e_max));
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
